// File: rtl/fp_sqrt_if.sv
// Handshake and operand/result bundle for the sequential floating-point square root.
interface fp_sqrt_if #(
    parameter int unsigned W = 32
) ();
    logic         start;
    logic [W-1:0] argument;
    logic [W-1:0] result;
    logic         done;
    logic         busy;
    logic         invalid;

    modport master (output start, argument, input result, done, busy, invalid);
    modport slave  (input start, argument, output result, done, busy, invalid);
endinterface

// File: rtl/fp_sqrt_seq.sv
// Sequential IEEE-style square root: one restoring root bit per cycle on the significand,
// with special-case bypass and optional round-to-nearest.
module fp_sqrt_seq #(
    parameter int unsigned EXP_W      = 8,
    parameter int unsigned MAN_W      = 23,
    parameter int unsigned ROUND_MODE = 1
) (
    input  logic     clk,
    input  logic     n_reset,
    fp_sqrt_if.slave bus
);
    localparam int unsigned W      = 1 + EXP_W + MAN_W;
    localparam int unsigned SE_W   = EXP_W + 2;
    localparam int unsigned ROOT_W = MAN_W + 2;
    localparam int unsigned REM_W  = MAN_W + 4;
    localparam int unsigned X_W    = 2 * ROOT_W;
    localparam int unsigned SIG_W  = MAN_W + 2;
    localparam int unsigned CNT_W  = $clog2(ROOT_W);
    localparam int unsigned BIAS   = (1 << (EXP_W - 1)) - 1;
    localparam logic [W-1:0] QNAN  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_UNPACK, S_ITER, S_ROUND} state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      arg_q, arg_d;
    logic [SE_W-1:0]   exp_q, exp_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [ROOT_W-1:0] root_q, root_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              special_q, special_d;
    logic [W-1:0]      spec_res_q, spec_res_d;
    logic              spec_inv_q, spec_inv_d;
    logic [W-1:0]      result_q, result_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              invalid_q, invalid_d;

    logic                   sign_w;
    logic [EXP_W-1:0]       e_fld;
    logic [MAN_W-1:0]       frac;
    logic signed [SE_W-1:0] e_unb;
    logic signed [SE_W-1:0] e_even;
    logic [ROOT_W-1:0]      rad;
    logic [REM_W-1:0]       rem_sh;
    logic [REM_W-1:0]       trial;
    logic                   rnd_inc;
    logic [SIG_W-1:0]       sig;
    logic [SE_W-1:0]        exp_r;
    logic [MAN_W-1:0]       frac_r;
    logic                   unused_bits;

    // State and datapath registers
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= S_IDLE;
            arg_q      <= '0;
            exp_q      <= '0;
            x_q        <= '0;
            rem_q      <= '0;
            root_q     <= '0;
            cnt_q      <= '0;
            special_q  <= 1'b0;
            spec_res_q <= '0;
            spec_inv_q <= 1'b0;
            result_q   <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            invalid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            arg_q      <= arg_d;
            exp_q      <= exp_d;
            x_q        <= x_d;
            rem_q      <= rem_d;
            root_q     <= root_d;
            cnt_q      <= cnt_d;
            special_q  <= special_d;
            spec_res_q <= spec_res_d;
            spec_inv_q <= spec_inv_d;
            result_q   <= result_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            invalid_q  <= invalid_d;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d     = state_q;
        arg_d       = arg_q;
        exp_d       = exp_q;
        x_d         = x_q;
        rem_d       = rem_q;
        root_d      = root_q;
        cnt_d       = cnt_q;
        special_d   = special_q;
        spec_res_d  = spec_res_q;
        spec_inv_d  = spec_inv_q;
        result_d    = result_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        invalid_d   = invalid_q;
        sign_w      = arg_q[W-1];
        e_fld       = arg_q[W-2:MAN_W];
        frac        = arg_q[MAN_W-1:0];
        e_unb       = '0;
        e_even      = '0;
        rad         = '0;
        rem_sh      = {rem_q[REM_W-3:0], x_q[X_W-1 -: 2]};
        trial       = {root_q, 2'b01};
        rnd_inc     = (ROUND_MODE == 1) ? root_q[0] : 1'b0;
        sig         = {1'b0, root_q[ROOT_W-1:1]} + SIG_W'(rnd_inc);
        exp_r       = exp_q;
        frac_r      = sig[MAN_W-1:0];
        unused_bits = ^{exp_r[SE_W-1:EXP_W], sig[MAN_W], rem_q[REM_W-1:REM_W-2]};

        // busy covers the done cycle and drops on the following edge
        if (done_q) busy_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start && !busy_q) begin
                    arg_d   = bus.argument;
                    busy_d  = 1'b1;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                special_d  = 1'b1;
                spec_inv_d = 1'b0;
                if (e_fld == '0) begin
                    spec_res_d = {sign_w, {(W - 1){1'b0}}};
                end else if (e_fld == '1) begin
                    if (frac != '0) begin
                        spec_res_d = QNAN;
                    end else if (sign_w) begin
                        spec_res_d = QNAN;
                        spec_inv_d = 1'b1;
                    end else begin
                        spec_res_d = arg_q;
                    end
                end else if (sign_w) begin
                    spec_res_d = QNAN;
                    spec_inv_d = 1'b1;
                end else begin
                    // Fold an odd exponent into the radicand so it lands in [1,4)
                    special_d = 1'b0;
                    e_unb     = SE_W'(e_fld) - SE_W'(BIAS);
                    if (e_unb[0]) begin
                        rad    = {1'b1, frac, 1'b0};
                        e_even = e_unb - SE_W'(1);
                    end else begin
                        rad    = {2'b01, frac};
                        e_even = e_unb;
                    end
                    exp_d  = (e_even >>> 1) + SE_W'(BIAS);
                    x_d    = {rad, {ROOT_W{1'b0}}};
                    rem_d  = '0;
                    root_d = '0;
                    cnt_d  = CNT_W'(ROOT_W - 1);
                end
                state_d = special_d ? S_ROUND : S_ITER;
            end
            S_ITER: begin
                if (rem_sh >= trial) begin
                    rem_d  = rem_sh - trial;
                    root_d = {root_q[ROOT_W-2:0], 1'b1};
                end else begin
                    rem_d  = rem_sh;
                    root_d = {root_q[ROOT_W-2:0], 1'b0};
                end
                x_d = {x_q[X_W-3:0], 2'b00};
                if (cnt_q == '0) state_d = S_ROUND;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_ROUND: begin
                if (special_q) begin
                    result_d  = spec_res_q;
                    invalid_d = spec_inv_q;
                end else begin
                    if (sig[MAN_W+1]) begin
                        exp_r  = exp_q + SE_W'(1);
                        frac_r = '0;
                    end
                    result_d  = {1'b0, exp_r[EXP_W-1:0], frac_r};
                    invalid_d = 1'b0;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.result  = result_q;
    assign bus.done    = done_q;
    assign bus.busy    = busy_q;
    assign bus.invalid = invalid_q;
endmodule

// File: tb/tb_fp_sqrt_seq.sv
// Scoreboard bench for fp_sqrt_seq: single precision (both rounding modes) and half precision.
module tb_fp_sqrt_seq;
    logic clk = 1'b0;
    logic n_reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fp_sqrt_if #(.W(32)) bus_sp ();
    fp_sqrt_if #(.W(32)) bus_tr ();
    fp_sqrt_if #(.W(16)) bus_hp ();

    fp_sqrt_seq #(.EXP_W(8), .MAN_W(23), .ROUND_MODE(1)) u_sp (.clk(clk), .n_reset(n_reset), .bus(bus_sp));
    fp_sqrt_seq #(.EXP_W(8), .MAN_W(23), .ROUND_MODE(0)) u_tr (.clk(clk), .n_reset(n_reset), .bus(bus_tr));
    fp_sqrt_seq #(.EXP_W(5), .MAN_W(10), .ROUND_MODE(1)) u_hp (.clk(clk), .n_reset(n_reset), .bus(bus_hp));

    typedef struct {
        logic [31:0] res;
        logic        inv;
        int          lat;
        int          t0;
        int          idx;
    } exp_t;

    exp_t q_sp[$];
    exp_t q_tr[$];
    exp_t q_hp[$];

    int checks = 0;
    int errors = 0;
    int seq = 0;
    bit after_sp = 1'b0;
    bit after_tr = 1'b0;
    bit after_hp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic busy_of(input int id);
        case (id)
            0:       return bus_sp.busy;
            1:       return bus_tr.busy;
            default: return bus_hp.busy;
        endcase
    endfunction

    task automatic drive(input int id, input logic s, input logic [31:0] a);
        case (id)
            0:       begin bus_sp.start = s; bus_sp.argument = a; end
            1:       begin bus_tr.start = s; bus_tr.argument = a; end
            default: begin bus_hp.start = s; bus_hp.argument = a[15:0]; end
        endcase
    endtask

    // Wait for the unit to be free, present the operand, record the expectation at the accept edge
    task automatic issue(input int id, input logic [31:0] arg, input logic [31:0] res,
                         input logic inv, input int lat, input bit hold);
        int   n;
        exp_t e;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy_of(id) && n < 100);
        chk("issue_wait_idle", 32'(busy_of(id)), 32'd0);
        drive(id, 1'b1, arg);
        @(posedge clk);
        #1;
        e.res = res; e.inv = inv; e.lat = lat; e.t0 = cyc; e.idx = seq;
        seq++;
        case (id)
            0:       q_sp.push_back(e);
            1:       q_tr.push_back(e);
            default: q_hp.push_back(e);
        endcase
        if (!hold) begin
            @(negedge clk);
            drive(id, 1'b0, arg);
        end
    endtask

    task automatic score(input exp_t e, input logic [31:0] res, input logic inv, input logic bsy);
        chk($sformatf("op%0d_result", e.idx), res, e.res);
        chk($sformatf("op%0d_invalid", e.idx), 32'(inv), 32'(e.inv));
        chk($sformatf("op%0d_latency", e.idx), 32'(cyc - e.t0), 32'(e.lat));
        chk($sformatf("op%0d_busy_at_done", e.idx), 32'(bsy), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_sp.size() + q_tr.size() + q_hp.size()) != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(q_sp.size() + q_tr.size() + q_hp.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Monitors: pop and compare on each done; check busy drops one cycle later
    always @(negedge clk) begin
        if (after_sp) begin
            chk("sp_busy_after_done", 32'(bus_sp.busy), 32'd0);
            after_sp = 1'b0;
        end
        if (bus_sp.done) begin
            if (q_sp.size() == 0) begin
                checks++; errors++;
                $display("FAIL sp_unexpected_done actual=done required=no_done");
            end else begin
                score(q_sp.pop_front(), bus_sp.result, bus_sp.invalid, bus_sp.busy);
                after_sp = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (after_tr) begin
            chk("tr_busy_after_done", 32'(bus_tr.busy), 32'd0);
            after_tr = 1'b0;
        end
        if (bus_tr.done) begin
            if (q_tr.size() == 0) begin
                checks++; errors++;
                $display("FAIL tr_unexpected_done actual=done required=no_done");
            end else begin
                score(q_tr.pop_front(), bus_tr.result, bus_tr.invalid, bus_tr.busy);
                after_tr = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (after_hp) begin
            chk("hp_busy_after_done", 32'(bus_hp.busy), 32'd0);
            after_hp = 1'b0;
        end
        if (bus_hp.done) begin
            if (q_hp.size() == 0) begin
                checks++; errors++;
                $display("FAIL hp_unexpected_done actual=done required=no_done");
            end else begin
                score(q_hp.pop_front(), 32'(bus_hp.result), bus_hp.invalid, bus_hp.busy);
                after_hp = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        drive(0, 1'b0, 32'h0);
        drive(1, 1'b0, 32'h0);
        drive(2, 1'b0, 32'h0);
        #12;
        chk("rst_result", bus_sp.result, 32'h0);
        chk("rst_done", 32'(bus_sp.done), 32'd0);
        chk("rst_busy", 32'(bus_sp.busy), 32'd0);
        chk("rst_invalid", 32'(bus_sp.invalid), 32'd0);
        chk("rst_hp_result", 32'(bus_hp.result), 32'h0);
        repeat (2) @(negedge clk);
        n_reset = 1'b1;

        issue(0, 32'h40800000, 32'h40000000, 1'b0, 27, 1'b0);
        issue(0, 32'h3E800000, 32'h3F000000, 1'b0, 27, 1'b0);
        issue(0, 32'h40400000, 32'h3FDDB3D7, 1'b0, 27, 1'b0);
        issue(0, 32'h40A00000, 32'h400F1BBD, 1'b0, 27, 1'b0);
        issue(1, 32'h40A00000, 32'h400F1BBC, 1'b0, 27, 1'b0);
        issue(2, 32'h00004400, 32'h00004000, 1'b0, 14, 1'b0);
        issue(2, 32'h00004000, 32'h00003DA8, 1'b0, 14, 1'b0);
        issue(0, 32'hBF800000, 32'h7FC00000, 1'b1, 2, 1'b0);
        issue(0, 32'h80000000, 32'h80000000, 1'b0, 2, 1'b0);
        issue(0, 32'h7F800000, 32'h7F800000, 1'b0, 2, 1'b0);
        issue(0, 32'h7F800001, 32'h7FC00000, 1'b0, 2, 1'b0);
        issue(0, 32'h00000001, 32'h00000000, 1'b0, 2, 1'b0);

        // start held across two operands; operand scrambled while busy
        issue(0, 32'h40400000, 32'h3FDDB3D7, 1'b0, 27, 1'b1);
        @(negedge clk);
        bus_sp.argument = 32'hBF800000;
        repeat (5) @(negedge clk);
        bus_sp.argument = 32'h7F800001;
        issue(0, 32'h3E800000, 32'h3F000000, 1'b0, 27, 1'b0);
        drain();

        // leave a nonzero result, then abort an operation with a mid-cycle reset
        issue(0, 32'h40A00000, 32'h400F1BBD, 1'b0, 27, 1'b0);
        drain();
        bus_sp.start = 1'b1;
        bus_sp.argument = 32'h40800000;
        @(posedge clk);
        #1;
        bus_sp.start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        n_reset = 1'b0;
        #1;
        chk("abort_result", bus_sp.result, 32'h0);
        chk("abort_done", 32'(bus_sp.done), 32'd0);
        chk("abort_busy", 32'(bus_sp.busy), 32'd0);
        chk("abort_invalid", 32'(bus_sp.invalid), 32'd0);
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_idle_busy", 32'(bus_sp.busy), 32'd0);
        chk("abort_idle_result", bus_sp.result, 32'h0);

        issue(0, 32'h40800000, 32'h40000000, 1'b0, 27, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
